// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the FIFO pointer controller.
// Optional build macro used by fifo_ptr_ctrl: FIFO_ERR_STICKY_EN.
package fifo_pkg;

    localparam int DEFAULT_ADDR_W = 4;

    // Widths up to 32 bits; callers truncate the result to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr.sv
// Binary/Gray pointer register pair with an increment enable.
// The next-state values are exposed so the parent can derive registered flags.
module gray_ptr
    import fifo_pkg::*;
#(
    parameter int W = DEFAULT_ADDR_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next
);

    assign bin_next  = bin + {{(W-1){1'b0}}, inc};
    assign gray_next = W'(bin2gray(32'(bin_next)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/flag controller: Gray pointers, occupancy count and status flags.
// Build macro FIFO_ERR_STICKY_EN makes overflow/underflow sticky until reset.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int AF_LEVEL = (2 ** ADDR_W) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W:0]   rptr_gray,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    // Full: Gray pointers one lap apart differ in exactly the top two bits.
    localparam logic [ADDR_W:0] FULL_MASK = {2'b11, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W:0] AF_TH     = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_TH     = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W:0] wptr_bin, rptr_bin;
    logic [ADDR_W:0] wbin_next, rbin_next;
    logic [ADDR_W:0] wgray_next, rgray_next;
    logic [ADDR_W:0] count_next;
    logic            ovf_evt, udf_evt;

    // Handshake: wr_req/rd_req are requests; wr_en/rd_en grant them in the same
    // cycle only when there is room/data. A refused request is dropped, moves
    // no pointer, and is reported one edge later on overflow/underflow.
    assign wr_en   = wr_req & ~full;
    assign rd_en   = rd_req & ~empty;
    assign ovf_evt = wr_req & full;
    assign udf_evt = rd_req & empty;

    assign waddr = wptr_bin[ADDR_W-1:0];
    assign raddr = rptr_bin[ADDR_W-1:0];

    gray_ptr #(.W(ADDR_W + 1)) u_wptr (
        .clk       (clk),
        .rst       (rst),
        .inc       (wr_en),
        .bin       (wptr_bin),
        .gray      (wptr_gray),
        .bin_next  (wbin_next),
        .gray_next (wgray_next)
    );

    gray_ptr #(.W(ADDR_W + 1)) u_rptr (
        .clk       (clk),
        .rst       (rst),
        .inc       (rd_en),
        .bin       (rptr_bin),
        .gray      (rptr_gray),
        .bin_next  (rbin_next),
        .gray_next (rgray_next)
    );

    assign count_next = wbin_next - rbin_next;

    // Flags are computed from next-state pointers so they track a grant in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_next;
            full         <= ((wgray_next ^ rgray_next) == FULL_MASK);
            empty        <= (wgray_next == rgray_next);
            almost_full  <= (count_next >= AF_TH);
            almost_empty <= (count_next <= AE_TH);
`ifdef FIFO_ERR_STICKY_EN
            overflow     <= overflow | ovf_evt;
            underflow    <= underflow | udf_evt;
`else
            overflow     <= ovf_evt;
            underflow    <= udf_evt;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl (ADDR_W=4): vector table, corner sequences, random traffic.
// Honours FIFO_ERR_STICKY_EN for the expected overflow/underflow behaviour.
module tb_fifo_ptr_ctrl;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req, rd_req;
    logic       wr_en, rd_en;
    logic [3:0] waddr, raddr;
    logic [4:0] wptr_gray, rptr_gray, count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: occupancy and free-running access counters.
    int m_wr, m_rd, m_occ;
    bit m_ovf, m_udf;

    typedef struct {
        bit wr;
        bit rd;
        int cnt;
        bit full;
        bit empty;
        bit af;
        bit ae;
    } vec_t;

    vec_t vecs[21];

    fifo_ptr_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .waddr        (waddr),
        .raddr        (raddr),
        .wptr_gray    (wptr_gray),
        .rptr_gray    (rptr_gray),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] t;
        t = 5'(b);
        return t ^ (t >> 1);
    endfunction

    function automatic vec_t mk(input bit wr, input bit rd, input int cnt,
                                input bit f, input bit e, input bit af, input bit ae);
        vec_t v;
        v.wr = wr; v.rd = rd; v.cnt = cnt;
        v.full = f; v.empty = e; v.af = af; v.ae = ae;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_occ = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic check_regs();
        chk("count",        32'(count),        32'(m_occ));
        chk("full",         32'(full),         32'(m_occ == DEPTH));
        chk("empty",        32'(empty),        32'(m_occ == 0));
        chk("almost_full",  32'(almost_full),  32'(m_occ >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(m_occ <= AE));
        chk("wptr_gray",    32'(wptr_gray),    32'(gray5(m_wr)));
        chk("rptr_gray",    32'(rptr_gray),    32'(gray5(m_rd)));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
    endtask

    task automatic cycle(input bit wr, input bit rd);
        bit gw, gr, oe, ue;
        @(negedge clk);
        wr_req = wr;
        rd_req = rd;
        #1;
        gw = wr && (m_occ < DEPTH);
        gr = rd && (m_occ > 0);
        chk("wr_en", 32'(wr_en), 32'(gw));
        chk("rd_en", 32'(rd_en), 32'(gr));
        chk("waddr", 32'(waddr), 32'(m_wr % DEPTH));
        chk("raddr", 32'(raddr), 32'(m_rd % DEPTH));
        @(posedge clk);
        oe = wr && (m_occ == DEPTH);
        ue = rd && (m_occ == 0);
        if (gw) begin m_wr = (m_wr + 1) % (2 * DEPTH); m_occ++; end
        if (gr) begin m_rd = (m_rd + 1) % (2 * DEPTH); m_occ--; end
`ifdef FIFO_ERR_STICKY_EN
        m_ovf = m_ovf | oe;
        m_udf = m_udf | ue;
`else
        m_ovf = oe;
        m_udf = ue;
`endif
        #1;
        check_regs();
    endtask

    initial begin
        logic [4:0] prev_wg, prev_rg;
        int p_wr, p_rd;

        // Expected-value table, hand-derived for AF=14, AE=2.
        vecs[0] = mk(0, 1, 0, 0, 1, 0, 1);   // read from empty: refused
        vecs[1] = mk(1, 1, 1, 0, 0, 0, 1);   // both at empty: write only
        for (int i = 2; i <= 16; i++) begin
            vecs[i] = mk(1, 0, i, i == 16, 0, i >= 14, i <= 2);
        end
        vecs[17] = mk(1, 0, 16, 1, 0, 1, 0); // write at full: refused
        vecs[18] = mk(1, 1, 15, 0, 0, 1, 0); // both at full: read only
        vecs[19] = mk(0, 1, 14, 0, 0, 1, 0);
        vecs[20] = mk(0, 1, 13, 0, 0, 0, 0);

        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("reset_waddr", 32'(waddr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            cycle(vecs[i].wr, vecs[i].rd);
            chk($sformatf("vec%0d_count", i), 32'(count),        32'(vecs[i].cnt));
            chk($sformatf("vec%0d_full", i),  32'(full),         32'(vecs[i].full));
            chk($sformatf("vec%0d_empty", i), 32'(empty),        32'(vecs[i].empty));
            chk($sformatf("vec%0d_af", i),    32'(almost_full),  32'(vecs[i].af));
            chk($sformatf("vec%0d_ae", i),    32'(almost_empty), 32'(vecs[i].ae));
            if (i == 0)  chk("underflow_after_empty_read", 32'(underflow), 32'd1);
            if (i == 16) chk("wptr_gray_at_full", 32'(wptr_gray), 32'(5'b11000));
            if (i == 17) begin
                chk("overflow_after_full_write", 32'(overflow), 32'd1);
                chk("wptr_gray_held", 32'(wptr_gray), 32'(5'b11000));
            end
        end

        // Drain to 8, then streaming reads and writes across both pointer wraps.
        repeat (5) cycle(0, 1);
        chk("count_at_8", 32'(count), 32'd8);
        for (int i = 0; i < 40; i++) begin
            prev_wg = wptr_gray;
            prev_rg = rptr_gray;
            cycle(1, 1);
            chk("stream_count", 32'(count), 32'd8);
            chk("wgray_one_bit", 32'($countones(wptr_gray ^ prev_wg)), 32'd1);
            chk("rgray_one_bit", 32'($countones(rptr_gray ^ prev_rg)), 32'd1);
        end

        // Asynchronous reset at count 5, observed before any clock edge.
        repeat (3) cycle(0, 1);
        chk("count_at_5", 32'(count), 32'd5);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        chk("async_rst_waddr", 32'(waddr), 32'd0);
        chk("async_rst_raddr", 32'(raddr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 0);
        chk("post_rst_count", 32'(count), 32'd1);

        // Random traffic in phases with varying write/read bias.
        for (int ph = 0; ph < 8; ph++) begin
            p_wr = $urandom_range(9, 1);
            p_rd = $urandom_range(9, 1);
            for (int i = 0; i < 100; i++) begin
                cycle($urandom_range(9, 0) < p_wr, $urandom_range(9, 0) < p_rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
